multicycle_ctrl: RTL and testbench



---
 rtl/multicycle_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for the single-bus datapath: variable-length
// instruction flow, memory ready handshakes with timeout, branch resolution, sticky errors.
module multicycle_ctrl #(
  parameter int DATA_W   = 32,
  parameter int OPC_W    = 6,
  parameter int FUNC_W   = 4,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 32,
  parameter int SKIP_WB  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OPC_W-1:0]  opcode,
  input  logic [FUNC_W-1:0] func,
  input  logic [DATA_W-1:0] cond_val,
  input  logic              imem_ready,
  input  logic              dmem_ready,
  output logic              LoadPC,
  output logic              PCSel,
  output logic              ReadIM,
  output logic              LoadNPC,
  output logic              LoadIR,
  output logic              ReadRP,
  output logic              WriteRP,
  output logic              LoadA,
  output logic              LoadB,
  output logic              IMMsel,
  output logic              LoadIMM,
  output logic              MUXALU1,
  output logic              MUXALU2,
  output logic              LoadALUOut,
  output logic              ReadDM,
  output logic              WriteDM,
  output logic              LoadLMD,
  output logic              MUXWB,
  output logic [FUNC_W-1:0] ALUFunc,
  output logic [1:0]        MUXMOVE,
  output logic              HALT,
  output logic              illegal,
  output logic [2:0]        state_out,
  output logic [CNT_W-1:0]  instr_count
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALTED = 3'd5,
    S_ERR    = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ill_q, ill_d;

  logic is_alu, is_imm, is_ld, is_st, is_br, is_bmi, is_bpl, is_bz;
  logic is_move, is_cmov, is_halt, is_nop, is_legal, is_mem, has_wb;
  logic mem_done, take, wait_hit;

  assign is_alu   = (opcode == OPC_W'(6'b000000));
  assign is_imm   = (opcode[OPC_W-1 -: 2] == 2'b11);
  assign is_ld    = (opcode == OPC_W'(6'b000001));
  assign is_st    = (opcode == OPC_W'(6'b000010));
  assign is_br    = (opcode == OPC_W'(6'b000011));
  assign is_bmi   = (opcode == OPC_W'(6'b000100));
  assign is_bpl   = (opcode == OPC_W'(6'b000101));
  assign is_bz    = (opcode == OPC_W'(6'b000110));
  assign is_move  = (opcode == OPC_W'(6'b000111));
  assign is_cmov  = (opcode == OPC_W'(6'b101010));
  assign is_halt  = (opcode == OPC_W'(6'b001000));
  assign is_nop   = (opcode == OPC_W'(6'b001001));
  assign is_legal = is_alu | is_imm | is_ld | is_st | is_br | is_bmi | is_bpl | is_bz |
                    is_move | is_cmov | is_halt | is_nop;
  assign is_mem   = is_ld | is_st;
  assign has_wb   = is_alu | is_imm | is_ld | is_move | is_cmov;

  assign mem_done = ~is_mem | dmem_ready;
  assign take     = is_br | (is_bmi & cond_val[DATA_W-1]) |
                    (is_bpl & ~cond_val[DATA_W-1]) | (is_bz & (cond_val == '0));
  assign wait_hit = (wait_q == 8'(WAIT_MAX - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      cnt_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      ill_q   <= ill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      S_FETCH: begin
        if (imem_ready)    state_d = S_DECODE;
        else if (wait_hit) state_d = S_ERR;
        else               wait_d  = 8'(wait_q + 8'd1);
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (!is_legal)    state_d = S_ERR;
        else if (is_halt) state_d = S_HALTED;
        else              state_d = S_MEM;
      end
      S_MEM: begin
        if (mem_done)      state_d = (has_wb || SKIP_WB == 0) ? S_WB : S_FETCH;
        else if (wait_hit) state_d = S_ERR;
        else               wait_d  = 8'(wait_q + 8'd1);
      end
      S_WB:     state_d = S_FETCH;
      S_HALTED: state_d = S_HALTED;
      S_ERR:    state_d = S_ERR;
      default:  state_d = S_ERR;
    endcase
    // the wait budget is per state visit
    if (state_d != state_q) wait_d = '0;
    cnt_d = cnt_q + CNT_W'(LoadPC);
    ill_d = ill_q | (state_d == S_ERR);
  end

  always_comb begin
    LoadPC = 1'b0; PCSel = 1'b0; ReadIM = 1'b0; LoadNPC = 1'b0; LoadIR = 1'b0;
    ReadRP = 1'b0; WriteRP = 1'b0; LoadA = 1'b0; LoadB = 1'b0; IMMsel = 1'b0;
    LoadIMM = 1'b0; MUXALU1 = 1'b0; MUXALU2 = 1'b0; LoadALUOut = 1'b0;
    ReadDM = 1'b0; WriteDM = 1'b0; LoadLMD = 1'b0; MUXWB = 1'b0;
    ALUFunc = '0; MUXMOVE = 2'b00; HALT = 1'b0;
    illegal = 1'b0; state_out = 3'd0; instr_count = '0;
    if (!rst) begin
      illegal     = ill_q;
      state_out   = state_q;
      instr_count = cnt_q;
      case (state_q)
        S_FETCH: begin
          ReadIM  = 1'b1;
          LoadNPC = imem_ready;
        end
        S_DECODE: LoadIR = 1'b1;
        S_EXEC: begin
          if (is_alu) begin
            ReadRP = 1'b1; LoadA = 1'b1; LoadB = 1'b1; LoadALUOut = 1'b1;
            ALUFunc = func;
          end else if (is_imm) begin
            ReadRP = 1'b1; LoadA = 1'b1; LoadIMM = 1'b1; MUXALU2 = 1'b1; LoadALUOut = 1'b1;
            ALUFunc = FUNC_W'(opcode[3:0]);
          end else if (is_mem) begin
            ReadRP = 1'b1; LoadA = 1'b1; LoadB = 1'b1; LoadIMM = 1'b1;
            MUXALU2 = 1'b1; LoadALUOut = 1'b1;
          end else if (is_br) begin
            LoadIMM = 1'b1; IMMsel = 1'b1; MUXALU2 = 1'b1; LoadALUOut = 1'b1;
          end else if (is_bmi || is_bpl || is_bz) begin
            ReadRP = 1'b1; LoadA = 1'b1; LoadIMM = 1'b1;
            MUXALU1 = 1'b1; MUXALU2 = 1'b1; LoadALUOut = 1'b1;
          end else if (is_move) begin
            LoadA = 1'b1;
          end else if (is_cmov) begin
            LoadA = 1'b1; LoadB = 1'b1;
          end
        end
        S_MEM: begin
          ReadDM  = is_ld;
          WriteDM = is_st;
          if (mem_done) begin
            LoadPC  = 1'b1;
            LoadLMD = is_ld;
            PCSel   = take;
          end
        end
        S_WB: begin
          if (is_alu || is_imm) begin
            MUXWB = 1'b1; WriteRP = 1'b1;
          end else if (is_ld) begin
            WriteRP = 1'b1;
          end else if (is_move) begin
            MUXMOVE = 2'b10; WriteRP = 1'b1;
          end else if (is_cmov) begin
            MUXMOVE = 2'b01; WriteRP = 1'b1;
          end
        end
        S_HALTED, S_ERR: HALT = 1'b1;
        default: HALT = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench: an instruction-level model expands each instruction into its
// expected per-cycle outputs, queued for a monitor that compares the DUT every cycle.
module tb_multicycle_ctrl;
  localparam int WAIT_MAX = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode;
  logic [3:0]  func;
  logic [31:0] cond_val;
  logic        imem_ready, dmem_ready;
  logic LoadPC, PCSel, ReadIM, LoadNPC, LoadIR, ReadRP, WriteRP, LoadA, LoadB, IMMsel;
  logic LoadIMM, MUXALU1, MUXALU2, LoadALUOut, ReadDM, WriteDM, LoadLMD, MUXWB;
  logic [3:0]  ALUFunc;
  logic [1:0]  MUXMOVE;
  logic        HALT, illegal;
  logic [2:0]  state_out;
  logic [31:0] instr_count;

  multicycle_ctrl #(.DATA_W(32), .OPC_W(6), .FUNC_W(4), .WAIT_MAX(WAIT_MAX),
                    .CNT_W(32), .SKIP_WB(1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func), .cond_val(cond_val),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .LoadPC(LoadPC), .PCSel(PCSel), .ReadIM(ReadIM), .LoadNPC(LoadNPC), .LoadIR(LoadIR),
    .ReadRP(ReadRP), .WriteRP(WriteRP), .LoadA(LoadA), .LoadB(LoadB), .IMMsel(IMMsel),
    .LoadIMM(LoadIMM), .MUXALU1(MUXALU1), .MUXALU2(MUXALU2), .LoadALUOut(LoadALUOut),
    .ReadDM(ReadDM), .WriteDM(WriteDM), .LoadLMD(LoadLMD), .MUXWB(MUXWB),
    .ALUFunc(ALUFunc), .MUXMOVE(MUXMOVE), .HALT(HALT), .illegal(illegal),
    .state_out(state_out), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic LoadPC, PCSel, ReadIM, LoadNPC, LoadIR, ReadRP, WriteRP, LoadA, LoadB, IMMsel;
    logic LoadIMM, MUXALU1, MUXALU2, LoadALUOut, ReadDM, WriteDM, LoadLMD, MUXWB;
    logic [3:0]  alu;
    logic [1:0]  mv;
    logic        halt, ill;
    logic [31:0] cnt;
  } obs_t;

  obs_t exp_q[$];
  obs_t mon_e, mon_a;
  int   n_cmp = 0, n_bad = 0, n_cyc = 0;
  int   cnt_m = 0;

  function automatic obs_t sample();
    obs_t a;
    a = '0;
    a.st = state_out; a.LoadPC = LoadPC; a.PCSel = PCSel; a.ReadIM = ReadIM;
    a.LoadNPC = LoadNPC; a.LoadIR = LoadIR; a.ReadRP = ReadRP; a.WriteRP = WriteRP;
    a.LoadA = LoadA; a.LoadB = LoadB; a.IMMsel = IMMsel; a.LoadIMM = LoadIMM;
    a.MUXALU1 = MUXALU1; a.MUXALU2 = MUXALU2; a.LoadALUOut = LoadALUOut;
    a.ReadDM = ReadDM; a.WriteDM = WriteDM; a.LoadLMD = LoadLMD; a.MUXWB = MUXWB;
    a.alu = ALUFunc; a.mv = MUXMOVE; a.halt = HALT; a.ill = illegal; a.cnt = instr_count;
    return a;
  endfunction

  // monitor: every driven cycle has an expected record waiting
  initial forever begin
    @(negedge clk);
    #2;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = sample();
      n_cmp++;
      if (mon_a !== mon_e) begin
        n_bad++;
        $display("FAIL cycle%0d outputs: got st=%0d vec=%h, want st=%0d vec=%h",
                 n_cyc, mon_a.st, mon_a, mon_e.st, mon_e);
      end
      n_cyc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic obs_t base(input logic [2:0] st);
    obs_t e;
    e = '0;
    e.st   = st;
    e.cnt  = 32'(cnt_m);
    e.halt = (st == 3'd5) || (st == 3'd6);
    e.ill  = (st == 3'd6);
    return e;
  endfunction

  task automatic cyc(input logic r, input logic [5:0] op, input logic [3:0] fn,
                     input logic [31:0] cv, input logic im, input logic dm, input obs_t e);
    @(negedge clk);
    rst = r; opcode = op; func = fn; cond_val = cv; imem_ready = im; dmem_ready = dm;
    exp_q.push_back(e);
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  task automatic do_reset(input int n);
    cnt_m = 0;
    for (int i = 0; i < n; i++)
      cyc(1'b1, 6'($urandom), 4'($urandom), $urandom, rb(), rb(), obs_t'(0));
  endtask

  task automatic hold(input int n, input logic [2:0] st);
    for (int i = 0; i < n; i++)
      cyc(1'b0, 6'($urandom), 4'($urandom), $urandom, rb(), rb(), base(st));
  endtask

  // fin: 0 retired normally, 5 halted, 6 error, 7 aborted by reset in MEM
  task automatic run_instr(input logic [5:0] op, input logic [3:0] fn, input logic [31:0] cv,
                           input int iw, input int dw, input int rst_at, output int fin);
    obs_t e;
    logic alu, imm, ld, st, br, bmi, bpl, bz, mv, cmv, hlt, nop, ok, take;
    alu = (op == 6'd0);  imm = (op[5:4] == 2'b11); ld = (op == 6'd1); st = (op == 6'd2);
    br  = (op == 6'd3);  bmi = (op == 6'd4); bpl = (op == 6'd5); bz = (op == 6'd6);
    mv  = (op == 6'd7);  cmv = (op == 6'd42); hlt = (op == 6'd8); nop = (op == 6'd9);
    ok  = alu | imm | ld | st | br | bmi | bpl | bz | mv | cmv | hlt | nop;
    take = br | (bmi & cv[31]) | (bpl & ~cv[31]) | (bz & (cv == 0));
    fin = 0;
    for (int k = 0; k < iw; k++) begin
      e = base(3'd0); e.ReadIM = 1'b1;
      cyc(1'b0, 6'($urandom), 4'($urandom), $urandom, 1'b0, rb(), e);
      if (k + 1 == WAIT_MAX) begin fin = 6; return; end
    end
    e = base(3'd0); e.ReadIM = 1'b1; e.LoadNPC = 1'b1;
    cyc(1'b0, 6'($urandom), 4'($urandom), $urandom, 1'b1, rb(), e);
    e = base(3'd1); e.LoadIR = 1'b1;
    cyc(1'b0, op, fn, cv, rb(), rb(), e);
    e = base(3'd2);
    if (alu) begin
      e.ReadRP = 1; e.LoadA = 1; e.LoadB = 1; e.LoadALUOut = 1; e.alu = fn;
    end else if (imm) begin
      e.ReadRP = 1; e.LoadA = 1; e.LoadIMM = 1; e.MUXALU2 = 1; e.LoadALUOut = 1; e.alu = op[3:0];
    end else if (ld || st) begin
      e.ReadRP = 1; e.LoadA = 1; e.LoadB = 1; e.LoadIMM = 1; e.MUXALU2 = 1; e.LoadALUOut = 1;
    end else if (br) begin
      e.LoadIMM = 1; e.IMMsel = 1; e.MUXALU2 = 1; e.LoadALUOut = 1;
    end else if (bmi || bpl || bz) begin
      e.ReadRP = 1; e.LoadA = 1; e.LoadIMM = 1; e.MUXALU1 = 1; e.MUXALU2 = 1; e.LoadALUOut = 1;
    end else if (mv) begin
      e.LoadA = 1;
    end else if (cmv) begin
      e.LoadA = 1; e.LoadB = 1;
    end
    cyc(1'b0, op, fn, cv, rb(), rb(), e);
    if (!ok) begin fin = 6; return; end
    if (hlt) begin fin = 5; return; end
    if (ld || st) begin
      for (int k = 0; k < dw; k++) begin
        if (k == rst_at) begin
          cnt_m = 0;
          cyc(1'b1, op, fn, cv, rb(), 1'b0, obs_t'(0));
          fin = 7; return;
        end
        e = base(3'd3); e.ReadDM = ld; e.WriteDM = st;
        cyc(1'b0, op, fn, cv, rb(), 1'b0, e);
        if (k + 1 == WAIT_MAX) begin fin = 6; return; end
      end
      e = base(3'd3); e.ReadDM = ld; e.WriteDM = st; e.LoadPC = 1; e.LoadLMD = ld;
      cyc(1'b0, op, fn, cv, rb(), 1'b1, e);
    end else begin
      e = base(3'd3); e.LoadPC = 1; e.PCSel = take;
      cyc(1'b0, op, fn, cv, rb(), rb(), e);
    end
    cnt_m++;
    if (alu || imm || ld || mv || cmv) begin
      e = base(3'd4); e.WriteRP = 1;
      e.MUXWB = alu | imm;
      e.mv = mv ? 2'b10 : (cmv ? 2'b01 : 2'b00);
      cyc(1'b0, op, fn, cv, rb(), rb(), e);
    end
  endtask

  function automatic logic [5:0] rand_legal();
    logic [5:0] tbl [10];
    int i;
    tbl = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd42, 6'd9};
    i = $urandom_range(0, 10);
    if (i == 10) return {2'b11, 4'($urandom)};
    return tbl[i];
  endfunction

  initial begin
    int fin;
    rst = 1'b1; opcode = '0; func = '0; cond_val = '0; imem_ready = 1'b0; dmem_ready = 1'b0;
    do_reset(2);
    // directed: ADDI, LD with data wait, branches
    run_instr(6'b110000, 4'($urandom), $urandom, 0, 0, -1, fin);
    run_instr(6'd1, 4'h3, $urandom, 0, 3, -1, fin);
    run_instr(6'd6, 4'h0, 32'd0, 0, 0, -1, fin);
    run_instr(6'd6, 4'h0, 32'd5, 0, 0, -1, fin);
    run_instr(6'd4, 4'h0, 32'h8000_0000, 1, 0, -1, fin);
    run_instr(6'd5, 4'h0, 32'h8000_0000, 0, 0, -1, fin);
    run_instr(6'd3, 4'h0, $urandom, 2, 0, -1, fin);
    run_instr(6'b111111, 4'h0, $urandom, 0, 0, -1, fin);
    // random mix
    for (int n = 0; n < 60; n++) begin
      logic [31:0] cv;
      cv = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      run_instr(rand_legal(), 4'($urandom), cv, $urandom_range(0, 4),
                $urandom_range(0, 4), -1, fin);
    end
    // longest waits that still complete, then a data timeout
    run_instr(6'd0, 4'h5, $urandom, WAIT_MAX - 1, 0, -1, fin);
    run_instr(6'd2, 4'h0, $urandom, 0, WAIT_MAX - 1, -1, fin);
    run_instr(6'd2, 4'h0, $urandom, WAIT_MAX - 1, WAIT_MAX, -1, fin);
    hold(3, 3'd6);
    do_reset(1);
    // instruction fetch timeout
    run_instr(6'd0, 4'h1, $urandom, WAIT_MAX, 0, -1, fin);
    hold(3, 3'd6);
    do_reset(1);
    // undefined opcode
    run_instr(6'd0, 4'h2, $urandom, 0, 0, -1, fin);
    run_instr(6'b011011, 4'h0, $urandom, 0, 0, -1, fin);
    hold(3, 3'd6);
    do_reset(1);
    // HALT keeps count frozen, illegal low
    run_instr(6'd7, 4'h0, $urandom, 0, 0, -1, fin);
    run_instr(6'd8, 4'h0, $urandom, 0, 0, -1, fin);
    hold(4, 3'd5);
    do_reset(1);
    // reset during a stalled store
    run_instr(6'd9, 4'h0, $urandom, 0, 0, -1, fin);
    run_instr(6'd2, 4'h0, $urandom, 0, 5, 2, fin);
    run_instr(6'd0, 4'h7, $urandom, 0, 0, -1, fin);
    run_instr(6'd42, 4'h0, $urandom, 0, 0, -1, fin);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    #3;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
